// File: rtl/pwm_fader_array.sv
// pwm_fader_array: multi-channel PWM LED driver with static duty and sync/staggered breathing modes.
// Mode, duty and levels only change at frame boundaries so a frame is never torn.
module pwm_fader_array #(
    parameter int CLK_FREQ     = 25_000_000,
    parameter int PWM_FREQ     = 1_250,
    parameter int CHANNELS     = 8,
    parameter int RES          = 8,
    parameter int STEP_PERIODS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [RES-1:0]      duty,
    output logic [CHANNELS-1:0] leds,
    output logic                period_tick
);
    localparam int PRESC_RAW = CLK_FREQ / (PWM_FREQ * (2 ** RES));
    localparam int PRESC     = PRESC_RAW < 1 ? 1 : PRESC_RAW;
    localparam int PW        = PRESC > 1 ? $clog2(PRESC) : 1;
    localparam int SW        = STEP_PERIODS > 1 ? $clog2(STEP_PERIODS) : 1;
    localparam int PHW       = RES + 1;
    localparam int OFS       = (2 ** PHW) / CHANNELS;

    logic [PW-1:0]                presc_cnt;
    logic [RES-1:0]               pwm_cnt;
    logic [RES-1:0]               pwm_nxt;
    logic [SW-1:0]                step_cnt;
    logic [RES:0]                 phase;
    logic [CHANNELS-1:0][RES-1:0] level;
    logic [CHANNELS-1:0][RES-1:0] lvl_src;
    logic [CHANNELS-1:0][RES-1:0] lvl_nxt;
    logic                         tick;
    logic                         fb;
    logic                         adv;
    logic                         step;

    assign tick    = presc_cnt == PW'(PRESC - 1);
    assign fb      = tick && pwm_cnt == '1;
    assign pwm_nxt = tick ? pwm_cnt + 1'b1 : pwm_cnt;
    assign adv     = fb && mode[1] && en;
    assign step    = adv && step_cnt == SW'(STEP_PERIODS - 1);

    // Each channel folds its (optionally staggered) phase into a triangle level.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [RES:0] OFF = PHW'(c * OFS);
        logic [RES:0] p;
        assign p          = phase + (mode[0] ? OFF : '0);
        assign lvl_src[c] = mode == 2'b00 ? '0 : mode == 2'b01 ? duty : p[RES] ? ~p[RES-1:0] : p[RES-1:0];
        assign lvl_nxt[c] = fb ? lvl_src[c] : level[c];
    end

    // leds compare against next-cycle counter/levels so they line up with pwm_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            step_cnt    <= '0;
            phase       <= '0;
            level       <= '0;
            leds        <= '0;
            period_tick <= 1'b0;
        end else begin
            presc_cnt   <= tick ? '0 : presc_cnt + 1'b1;
            pwm_cnt     <= pwm_nxt;
            period_tick <= fb;
            if (fb) level <= lvl_src;
            if (adv) step_cnt <= step ? '0 : step_cnt + 1'b1;
            if (step) phase <= phase + 1'b1;
            for (int i = 0; i < CHANNELS; i++) leds[i] <= en && pwm_nxt < lvl_nxt[i];
        end
    end
endmodule

// File: tb/tb_pwm_fader_array.sv
// tb_pwm_fader_array: directed scenarios plus randomized run against a frame-level reference model.
module tb_pwm_fader_array;
    localparam int CH = 4, RES = 4, SP = 2, FR = 16, PH = 32;

    logic            clk = 0, rst = 1, en = 0;
    logic [1:0]      mode = 0;
    logic [RES-1:0]  duty = 0;
    logic [CH-1:0]   leds;
    logic            period_tick;
    int              n_cmp = 0, n_err = 0;

    pwm_fader_array #(.CLK_FREQ(160), .PWM_FREQ(10), .CHANNELS(CH), .RES(RES), .STEP_PERIODS(SP)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .duty(duty), .leds(leds), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int tri_of(int p);
        p = p % PH;
        return p < FR ? p : PH - 1 - p;
    endfunction

    // Reference: frame position, count of enabled breathing frames, latched levels.
    int            m_pos = 0, m_brth = 0;
    int            m_lvl [CH];
    logic [CH-1:0] m_leds = '0;
    logic          m_tick = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_pos = 0; m_brth = 0; m_leds = '0; m_tick = 0;
            for (int i = 0; i < CH; i++) m_lvl[i] = 0;
        end else begin
            m_tick = m_pos == FR - 1;
            if (m_tick) begin
                for (int i = 0; i < CH; i++)
                    m_lvl[i] = mode == 2'd0 ? 0 : mode == 2'd1 ? int'(duty) :
                               tri_of(m_brth / SP + (mode == 2'd3 ? i * PH / CH : 0));
                if (mode[1] && en) m_brth++;
            end
            m_pos = (m_pos + 1) % FR;
            for (int i = 0; i < CH; i++) m_leds[i] = en && m_pos < m_lvl[i];
        end
    end

    task automatic wait_tick();
        int k = 0;
        do begin @(negedge clk); k++; end while (!period_tick && k < 40);
        if (!period_tick) begin
            n_cmp++; n_err++;
            $display("FAIL wait_tick: period_tick=%b after %0d cycles, required 1", period_tick, k);
        end
    endtask

    task automatic frame_counts(output int c[CH], output logic [CH-1:0] first);
        first = leds;
        for (int i = 0; i < CH; i++) c[i] = 0;
        for (int k = 0; k < FR; k++) begin
            if (k > 0) @(negedge clk);
            for (int i = 0; i < CH; i++) c[i] += int'(leds[i]);
        end
    endtask

    task automatic test_reset();
        int k = 0;
        rst = 1; en = 0; mode = 0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (leds !== '0 || period_tick !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold: leds=%b tick=%b, required 0000 0", leds, period_tick);
            end
        end
        @(posedge clk); #1 rst = 0;
        do begin @(negedge clk); k++; end while (!period_tick && k < 40);
        n_cmp++;
        if (k !== 17) begin
            n_err++;
            $display("FAIL first_tick: first period_tick at cycle %0d, required 17", k);
        end
    endtask

    task automatic test_static();
        int c[CH]; logic [CH-1:0] f;
        int dv[4] = '{5, 0, 15, 3};
        en = 1; mode = 1; duty = 5;
        wait_tick();
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin duty = RES'(dv[j]); @(negedge clk); end
            if (j == 3) duty = 11;
            frame_counts(c, f);
            n_cmp++;
            if (f !== (dv[j] > 0 ? 4'hF : 4'h0)) begin
                n_err++;
                $display("FAIL static_first duty=%0d: leds=%b, required %b", dv[j], f, dv[j] > 0 ? 4'hF : 4'h0);
            end
            for (int i = 0; i < CH; i++) begin
                n_cmp++;
                if (c[i] !== dv[j]) begin
                    n_err++;
                    $display("FAIL static_count ch%0d: high %0d cycles, required %0d", i, c[i], dv[j]);
                end
            end
        end
        @(negedge clk);
        frame_counts(c, f);
        for (int i = 0; i < CH; i++) begin
            n_cmp++;
            if (c[i] !== 11) begin
                n_err++;
                $display("FAIL static_next_frame ch%0d: high %0d cycles, required 11", i, c[i]);
            end
        end
    endtask

    task automatic test_sync_breathe();
        int c[CH]; logic [CH-1:0] f;
        mode = 2;
        for (int fr = 0; fr < 70; fr++) begin
            @(negedge clk);
            frame_counts(c, f);
            for (int i = 0; i < CH; i++) begin
                n_cmp++;
                if (c[i] !== tri_of(fr / 2)) begin
                    n_err++;
                    $display("FAIL sync_breathe frame%0d ch%0d: level %0d, required %0d", fr, i, c[i], tri_of(fr / 2));
                end
            end
        end
    endtask

    task automatic restart(input logic [1:0] m);
        rst = 1; mode = m; en = 1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 0;
        wait_tick();
    endtask

    task automatic test_stagger();
        int c[CH]; logic [CH-1:0] f;
        int e0[CH] = '{0, 8, 15, 7};
        int e1[CH] = '{1, 9, 14, 6};
        restart(3);
        for (int fr = 0; fr < 3; fr++) begin
            if (fr > 0) @(negedge clk);
            frame_counts(c, f);
            for (int i = 0; i < CH; i++) begin
                n_cmp++;
                if (c[i] !== (fr < 2 ? e0[i] : e1[i])) begin
                    n_err++;
                    $display("FAIL stagger frame%0d ch%0d: level %0d, required %0d", fr, i, c[i], fr < 2 ? e0[i] : e1[i]);
                end
            end
        end
    endtask

    task automatic test_enable();
        int c[CH]; logic [CH-1:0] f; int hi = 0;
        restart(2);
        for (int fr = 0; fr < 6; fr++) begin
            if (fr > 0) @(negedge clk);
            frame_counts(c, f);
        end
        @(negedge clk);
        repeat (3) @(negedge clk);
        en = 0;
        @(negedge clk);
        n_cmp++;
        if (leds !== '0) begin
            n_err++;
            $display("FAIL enable_fall: leds=%b, required 0000", leds);
        end
        repeat (91) begin @(negedge clk); hi += $countones(leds); end
        n_cmp++;
        if (hi !== 0) begin
            n_err++;
            $display("FAIL enable_low: %0d high samples, required 0", hi);
        end
        en = 1;
        for (int fr = 0; fr < 5; fr++) begin
            @(negedge clk);
            frame_counts(c, f);
            for (int i = 0; i < CH; i++) begin
                n_cmp++;
                if (c[i] !== tri_of((fr + 7) / 2)) begin
                    n_err++;
                    $display("FAIL enable_resume frame%0d ch%0d: level %0d, required %0d", fr, i, c[i], tri_of((fr + 7) / 2));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int c[CH]; logic [CH-1:0] f;
        restart(2);
        for (int fr = 0; fr < 20; fr++) begin
            if (fr > 0) @(negedge clk);
            frame_counts(c, f);
        end
        @(negedge clk);
        repeat (5) @(negedge clk);
        rst = 1;
        @(negedge clk);
        n_cmp++;
        if (leds !== '0 || period_tick !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: leds=%b tick=%b, required 0000 0", leds, period_tick);
        end
        @(posedge clk); #1 rst = 0;
        wait_tick();
        for (int fr = 0; fr < 4; fr++) begin
            if (fr > 0) @(negedge clk);
            frame_counts(c, f);
            for (int i = 0; i < CH; i++) begin
                n_cmp++;
                if (c[i] !== tri_of(fr / 2)) begin
                    n_err++;
                    $display("FAIL mid_reset_restart frame%0d ch%0d: level %0d, required %0d", fr, i, c[i], tri_of(fr / 2));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            n_cmp += 2;
            if (leds !== m_leds) begin
                n_err++;
                $display("FAIL random_leds cycle%0d: leds=%b, required %b", k, leds, m_leds);
            end
            if (period_tick !== m_tick) begin
                n_err++;
                $display("FAIL random_tick cycle%0d: tick=%b, required %b", k, period_tick, m_tick);
            end
            rst = $urandom_range(0, 299) == 0;
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) duty = RES'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) en = ~en;
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_sync_breathe();
        test_stagger();
        test_enable();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
